// File: rtl/i2s_rx_deser_if.sv
// Received-word handshake bundle: the deserializer drives it (master),
// and the downstream RX FIFO consumes it (slave).
interface i2s_rx_deser_if;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        rx_chl;

  modport master (output rx_valid, rx_data, rx_chl, input rx_ready);
  modport slave  (input rx_valid, rx_data, rx_chl, output rx_ready);
endinterface

// File: rtl/i2s_rx_deser.sv
// I2S slave-mode receiver: synchronizes sck/ws/sd, frames left/right words and
// holds each in a single-entry valid/ready register. Optional: I2S_RX_TIMEOUT_EN.
module i2s_rx_deser #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           en_i,
  input  logic           pol_i,
  input  logic           lsb_i,
  input  logic [1:0]     fmt_i,
  input  logic [1:0]     dal_i,
  input  logic           sck_i,
  input  logic           ws_i,
  input  logic           sd_i,
  i2s_rx_deser_if.master rx,
  output logic           busy_o,
  output logic           ovf_o,
  output logic           short_o,
  output logic           to_o
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT, S_WAIT} state_t;

  logic [SYNC_STAGES-1:0] r_sck_s, r_ws_s, r_sd_s;
  logic        r_sck_h, r_stb, r_ws, r_sd;
  logic        r_ws_last, r_ws_seen;
  state_t      r_state, w_state_nx;
  logic [4:0]  r_cnt, w_cnt_nx;
  logic [31:0] r_sh, w_sh_nx;
  logic        r_lsb, r_wchl, w_wchl_nx;
  logic [1:0]  r_dal;
  logic        w_edge, w_wschg, w_last, w_start, w_done, w_short, w_ld_cfg, w_to_hit;
  logic        r_valid, r_chl, r_ovf, r_short;
  logic [31:0] r_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sck_s <= '0;
      r_ws_s  <= '0;
      r_sd_s  <= '0;
      r_sck_h <= 1'b0;
    end else begin
      r_sck_s <= {r_sck_s[SYNC_STAGES-2:0], sck_i};
      r_ws_s  <= {r_ws_s[SYNC_STAGES-2:0], ws_i};
      r_sd_s  <= {r_sd_s[SYNC_STAGES-2:0], sd_i};
      r_sck_h <= r_sck_s[SYNC_STAGES-1];
    end
  end

  assign w_edge = pol_i ? (r_sck_h & ~r_sck_s[SYNC_STAGES-1])
                        : (~r_sck_h & r_sck_s[SYNC_STAGES-1]);

  // Strobe is registered together with the ws/sd samples so all three stay aligned.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stb     <= 1'b0;
      r_ws      <= 1'b0;
      r_sd      <= 1'b0;
      r_ws_last <= 1'b0;
      r_ws_seen <= 1'b0;
    end else begin
      r_stb <= w_edge;
      r_ws  <= r_ws_s[SYNC_STAGES-1];
      r_sd  <= r_sd_s[SYNC_STAGES-1];
      if (r_stb) begin
        r_ws_last <= r_ws;
        r_ws_seen <= 1'b1;
      end
    end
  end

  // ws history is tracked even while disabled, so re-enable waits for a real boundary.
  assign w_wschg = r_stb && r_ws_seen && (r_ws != r_ws_last);
  assign w_last  = (r_cnt == {r_dal, 3'b111});

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sh_nx    = r_sh;
    w_wchl_nx  = r_wchl;
    w_start    = 1'b0;
    w_done     = 1'b0;
    w_short    = 1'b0;
    w_ld_cfg   = 1'b0;
    if (!en_i) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        S_IDLE, S_WAIT: if (w_wschg) w_start = 1'b1;
        S_DELAY:        if (r_stb) w_state_nx = S_SHIFT;
        S_SHIFT: begin
          if (w_wschg) begin
            w_start = 1'b1;
            w_short = 1'b1;
          end else if (r_stb) begin
            if (r_lsb) w_sh_nx[r_cnt] = r_sd;
            else       w_sh_nx = {r_sh[30:0], r_sd};
            if (w_last) begin
              w_done     = 1'b1;
              w_state_nx = S_WAIT;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = r_cnt + 5'd1;
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
      if (w_start) begin
        w_ld_cfg  = 1'b1;
        w_wchl_nx = r_ws;
        w_sh_nx   = '0;
        w_cnt_nx  = '0;
        if (fmt_i != 2'b01) begin
          w_state_nx = S_DELAY;
        end else begin
          w_sh_nx[0] = r_sd;
          w_cnt_nx   = 5'd1;
          w_state_nx = S_SHIFT;
        end
      end
      if (w_to_hit) begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_wchl  <= 1'b0;
      r_lsb   <= 1'b0;
      r_dal   <= 2'b00;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sh    <= w_sh_nx;
      r_wchl  <= w_wchl_nx;
      if (w_ld_cfg) begin
        r_lsb <= lsb_i;
        r_dal <= dal_i;
      end
    end
  end

  // Output holding register: a completed word either loads or is dropped as overflow.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chl   <= 1'b0;
      r_ovf   <= 1'b0;
      r_short <= 1'b0;
    end else begin
      r_ovf   <= w_done && r_valid && !rx.rx_ready;
      r_short <= w_short;
      if (!en_i) begin
        r_valid <= 1'b0;
      end else if (w_done && (!r_valid || rx.rx_ready)) begin
        r_valid <= 1'b1;
        r_data  <= w_sh_nx;
        r_chl   <= r_wchl;
      end else if (rx.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_to;

  assign w_to_hit = en_i && (r_state != S_IDLE) && !r_stb &&
                    (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_to_cnt <= '0;
      r_to     <= 1'b0;
    end else begin
      r_to <= w_to_hit;
      if (!en_i || (r_state == S_IDLE) || r_stb || w_to_hit) r_to_cnt <= '0;
      else                                                   r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
  assign to_o = r_to;
`else
  logic w_unused_to;
  assign w_unused_to = |TIMEOUT_CYC;
  assign w_to_hit    = 1'b0;
  assign to_o        = 1'b0;
`endif

  assign rx.rx_valid = r_valid;
  assign rx.rx_data  = r_data;
  assign rx.rx_chl   = r_chl;
  assign busy_o      = (r_state != S_IDLE);
  assign ovf_o       = r_ovf;
  assign short_o     = r_short;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Self-checking bench for i2s_rx_deser: vector table, randomized words against a
// word-level reference, and hand-written overflow/short/reset/timeout sequences.
module tb_i2s_rx_deser;
  localparam int S  = 2;
  localparam int HP = 3;
  localparam int TO = 64;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, pol = 1'b0, lsb = 1'b0;
  logic [1:0] fmt = 2'b00, dal = 2'b00;
  logic sck = 1'b0, ws = 1'b0, sd = 1'b0;
  logic busy, ovf, shrt, to;

  i2s_rx_deser_if rx();

  always #5 clk = ~clk;

  i2s_rx_deser #(.SYNC_STAGES(S), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pol_i(pol), .lsb_i(lsb),
    .fmt_i(fmt), .dal_i(dal), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .rx(rx), .busy_o(busy), .ovf_o(ovf), .short_o(shrt), .to_o(to)
  );

  typedef struct { logic [31:0] data; logic chl; int cyc; } got_t;
  typedef struct {
    logic p; logic l; logic [1:0] f; logic [1:0] d; logic ch; logic cont;
    logic [31:0] val; logic [31:0] exp;
  } vec_t;

  got_t got_q[$];
  int cyc = 0, n_ovf = 0, n_short = 0, n_to = 0;
  int checks = 0, fails = 0;
  int last_edge = 0, data_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx.rx_valid && rx.rx_ready) got_q.push_back('{rx.rx_data, rx.rx_chl, cyc});
    if (ovf)  n_ovf   <= n_ovf + 1;
    if (shrt) n_short <= n_short + 1;
    if (to)   n_to    <= n_to + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One serial bit: data set while sck is at its inactive level, then the sampling edge.
  task automatic bit_out(input logic w, input logic d);
    sck = pol; ws = w; sd = d;
    tick(HP);
    sck = ~pol;
    last_edge = cyc;
    tick(HP);
  endtask

  // Emits one channel slot using the current format; only `cut` data bits are sent.
  task automatic send_word(input logic ch, input logic [31:0] val, input int cut);
    int n;
    n = 8 * (int'(dal) + 1);
    if (fmt != 2'b01) repeat (2) bit_out(ch, 1'($urandom));
    for (int i = 0; i < cut; i++) begin
      bit_out(ch, val[lsb ? i : n - 1 - i]);
      if (i == n - 1) data_edge = last_edge;
    end
    if (cut == n) repeat (2) bit_out(ch, 1'($urandom));
  endtask

  task automatic prep(input logic p, input logic l, input logic [1:0] f,
                      input logic [1:0] d, input logic pre_ws);
    en = 1'b0;
    tick(1);
    pol = p; lsb = l; fmt = f; dal = d;
    bit_out(pre_ws, 1'b0);
    bit_out(pre_ws, 1'b0);
    en = 1'b1;
  endtask

  task automatic chk_word(input string nm, input logic [31:0] ed, input logic ec,
                          input int lat);
    int k;
    got_t g;
    k = 0;
    while (got_q.size() == 0 && k < 1000) begin
      tick(1);
      k++;
    end
    if (got_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: no word within 1000 cycles", nm);
    end else begin
      g = got_q.pop_front();
      chk({nm, " data"}, g.data, ed);
      chk({nm, " chl"}, {31'd0, g.chl}, {31'd0, ec});
      if (lat >= 0) chk({nm, " latency"}, g.cyc - data_edge, lat);
    end
  endtask

  vec_t tv[6];

  initial begin
    int o;
    logic pw, ch;
    logic [31:0] v, m;
    int n;

    tv[0] = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 32'h0000A5C3, 32'h0000A5C3};
    tv[1] = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 32'h00001234, 32'h00001234};
    tv[2] = '{1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0000000D, 32'h0000000D};
    tv[3] = '{1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[4] = '{1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 32'hFFABCDEF, 32'h00ABCDEF};
    tv[5] = '{1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'hFFFFFF80, 32'h00000080};

    rx.rx_ready = 1'b1;
    tick(3);
    chk("reset valid", {31'd0, rx.rx_valid}, 32'd0);
    chk("reset data", rx.rx_data, 32'd0);
    chk("reset flags", {27'd0, rx.rx_chl, busy, ovf, shrt, to}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      if (!tv[i].cont) prep(tv[i].p, tv[i].l, tv[i].f, tv[i].d, ~tv[i].ch);
      send_word(tv[i].ch, tv[i].val, 8 * (int'(tv[i].d) + 1));
      chk_word($sformatf("vec%0d", i), tv[i].exp, tv[i].ch, S + 2);
    end

    // Randomized batches: reference is simply the transmitted value truncated to N bits.
    for (int b = 0; b < 4; b++) begin
      pw = 1'($urandom);
      prep(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), pw);
      n = 8 * (int'(dal) + 1);
      m = (n == 32) ? 32'hFFFFFFFF : ((32'd1 << n) - 32'd1);
      ch = ~pw;
      for (int w = 0; w < 4; w++) begin
        v = $urandom;
        send_word(ch, v, n);
        chk_word($sformatf("rand b%0d w%0d", b, w), v & m, ch, -1);
        ch = ~ch;
      end
    end

    // Overflow: consumer stalled across two words.
    rx.rx_ready = 1'b0;
    prep(1'b0, 1'b0, 2'b01, 2'b00, 1'b1);
    o = n_ovf;
    send_word(1'b0, 32'h11, 8);
    send_word(1'b1, 32'h22, 8);
    tick(6);
    chk("ovf held valid", {31'd0, rx.rx_valid}, 32'd1);
    chk("ovf held data", rx.rx_data, 32'h11);
    chk("ovf held chl", {31'd0, rx.rx_chl}, 32'd0);
    chk("ovf pulse count", n_ovf - o, 32'd1);
    chk("ovf no transfer", got_q.size(), 32'd0);
    rx.rx_ready = 1'b1;
    tick(2);
    chk("ovf one transfer", got_q.size(), 32'd1);
    if (got_q.size() > 0) chk("ovf transfer data", got_q.pop_front().data, 32'h11);
    chk("ovf valid drops", {31'd0, rx.rx_valid}, 32'd0);

    // Short word: ws flips after 5 of 16 bits.
    prep(1'b0, 1'b0, 2'b01, 2'b01, 1'b1);
    o = n_short;
    send_word(1'b0, 32'hFFFF, 5);
    send_word(1'b1, 32'hBEEF, 16);
    chk_word("short next", 32'hBEEF, 1'b1, S + 2);
    chk("short pulse count", n_short - o, 32'd1);
    chk("short no extra", got_q.size(), 32'd0);

    // Reset mid-stream with a held word and a partial word in flight.
    rx.rx_ready = 1'b0;
    prep(1'b0, 1'b0, 2'b01, 2'b00, 1'b1);
    send_word(1'b0, 32'h5A, 8);
    send_word(1'b1, 32'h3C, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst valid", {31'd0, rx.rx_valid}, 32'd0);
    chk("midrst data", rx.rx_data, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    rx.rx_ready = 1'b1;
    tick(1);
    send_word(1'b1, 32'h0, 5);
    tick(20);
    chk("midrst no partial", got_q.size(), 32'd0);
    send_word(1'b0, 32'h96, 8);
    chk_word("midrst next", 32'h96, 1'b0, S + 2);

    // sck stops mid-word.
    prep(1'b0, 1'b0, 2'b01, 2'b01, 1'b1);
    o = n_to;
    send_word(1'b0, 32'hFFFF, 5);
    tick(40);
    chk("stall busy early", {31'd0, busy}, 32'd1);
    chk("stall no early to", n_to - o, 32'd0);
    tick(60);
`ifdef I2S_RX_TIMEOUT_EN
    chk("timeout pulse count", n_to - o, 32'd1);
    chk("timeout busy", {31'd0, busy}, 32'd0);
`else
    chk("no timeout pulse", n_to - o, 32'd0);
    chk("stall busy held", {31'd0, busy}, 32'd1);
`endif
    en = 1'b0;
    tick(1);
    chk("disable busy", {31'd0, busy}, 32'd0);
    chk("total short pulses", n_short, 32'd1);
    chk("total ovf pulses", n_ovf, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
